// File: rtl/x9_pkg.sv
// rtl/x9_pkg.sv - shared types and widths for the run sequencer
// Purpose: sequencer state encoding plus default program-counter and
//          counter widths used by the sequencer, its interface and bench.
// Ports:   none (package)
package x9_pkg;

  localparam int D  = 12;  // program-counter width
  localparam int CW = 16;  // instruction / cycle counter width

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_DONE
  } seq_state_t;

  // States in which the watchdog cycle counter advances.
  function automatic logic is_run_state(seq_state_t s);
    return (s == S_FETCH) || (s == S_DECODE) || (s == S_EXEC) ||
           (s == S_MEM)   || (s == S_WB);
  endfunction

endpackage

// File: rtl/run_sequencer_if.sv
// rtl/run_sequencer_if.sv - host/datapath <-> sequencer signal bundle
// Purpose: groups the run handshake, decoded-instruction inputs and the
//          control strobes of the run sequencer.
// Ports:   master = host/datapath side (drives req, prog_ctr, halt_pc,
//          is_load, is_store, reg_write; observes strobes and status)
//          slave  = sequencer side (the reverse)
interface run_sequencer_if #(
  parameter int D  = x9_pkg::D,
  parameter int CW = x9_pkg::CW
);

  logic          req;
  logic [D-1:0]  prog_ctr;
  logic [D-1:0]  halt_pc;
  logic          is_load;
  logic          is_store;
  logic          reg_write;

  logic          pc_clr;
  logic          ir_ld;
  logic          flag_en;
  logic          mem_wr_en;
  logic          rf_wr_en;
  logic          pc_en;
  logic          busy;
  logic          done;
  logic          timeout;
  logic [CW-1:0] instr_cnt;

  modport master (
    output req, prog_ctr, halt_pc, is_load, is_store, reg_write,
    input  pc_clr, ir_ld, flag_en, mem_wr_en, rf_wr_en, pc_en,
           busy, done, timeout, instr_cnt
  );

  modport slave (
    input  req, prog_ctr, halt_pc, is_load, is_store, reg_write,
    output pc_clr, ir_ld, flag_en, mem_wr_en, rf_wr_en, pc_en,
           busy, done, timeout, instr_cnt
  );

endinterface

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - clearable saturating up-counter
// Purpose: counts enabled cycles, sticks at all-ones instead of wrapping.
// Ports:   clk, reset (async active-low), clr (sync clear, wins over en),
//          en (count enable), cnt (current value)
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != '1)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/run_sequencer.sv
// rtl/run_sequencer.sv - multi-cycle instruction run sequencer with watchdog
// Purpose: walks FETCH/DECODE/EXEC/[MEM]/WB per instruction from a host
//          run request until halt_pc retires or the watchdog expires.
// Ports:   clk, reset (async active-low),
//          bus (slave modport): req/done handshake, prog_ctr, halt_pc,
//          decoded is_load/is_store/reg_write in; pc_clr, ir_ld, flag_en,
//          mem_wr_en, rf_wr_en, pc_en, busy, done, timeout, instr_cnt out.
module run_sequencer #(
  parameter int          D       = x9_pkg::D,
  parameter int          CW      = x9_pkg::CW,
  parameter int unsigned MAX_CYC = 4000
) (
  input  logic                 clk,
  input  logic                 reset,
  run_sequencer_if.slave       bus
);

  import x9_pkg::*;

  localparam logic [CW-1:0] WDOG_LAST = CW'(MAX_CYC - 1);

  seq_state_t    state_q;
  seq_state_t    state_d;
  logic          timeout_q;
  logic          timeout_d;

  logic [D-1:0]  pc_now;
  logic [D-1:0]  pc_halt;
  logic [CW-1:0] cyc_cnt;
  logic [CW-1:0] instr_cnt;
  logic          halt_hit;
  logic          wdog_fire;
  logic          run_clr;

  assign pc_now   = bus.prog_ctr;
  assign pc_halt  = bus.halt_pc;
  assign halt_hit = (pc_now == pc_halt);

  // Watchdog only looks at the counter while it is live; in DONE/IDLE the
  // stale count must not pin the FSM in DONE.
  assign wdog_fire = is_run_state(state_q) && (cyc_cnt == WDOG_LAST);

  // Counters and timeout clear on the transition into START so that
  // instr_cnt already reads 0 while START is the current state.
  assign run_clr = (state_d == S_START);

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      timeout_q <= timeout_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (bus.req) state_d = S_START;
      S_START:  state_d = S_FETCH;
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: state_d = S_EXEC;
      S_EXEC:   state_d = (bus.is_load || bus.is_store) ? S_MEM : S_WB;
      S_MEM:    state_d = S_WB;
      S_WB:     state_d = halt_hit ? S_DONE : S_FETCH;
      S_DONE:   if (!bus.req) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    // Watchdog beats every other transition, the WB halt check included.
    if (wdog_fire) begin
      state_d = S_DONE;
    end
  end

  always_comb begin
    timeout_d = timeout_q;
    if (run_clr) begin
      timeout_d = 1'b0;
    end else if (wdog_fire) begin
      timeout_d = 1'b1;
    end
  end

  // Output decode
  always_comb begin
    bus.pc_clr    = 1'b0;
    bus.ir_ld     = 1'b0;
    bus.flag_en   = 1'b0;
    bus.mem_wr_en = 1'b0;
    bus.rf_wr_en  = 1'b0;
    bus.pc_en     = 1'b0;
    bus.busy      = 1'b0;
    bus.done      = 1'b0;
    case (state_q)
      S_START:  begin bus.pc_clr = 1'b1; bus.busy = 1'b1; end
      S_FETCH:  begin bus.ir_ld  = 1'b1; bus.busy = 1'b1; end
      S_DECODE: bus.busy = 1'b1;
      S_EXEC:   begin bus.flag_en = 1'b1; bus.busy = 1'b1; end
      // A load+store combination writes memory, so only is_store gates it.
      S_MEM:    begin bus.mem_wr_en = bus.is_store; bus.busy = 1'b1; end
      S_WB: begin
        bus.rf_wr_en = bus.reg_write;
        bus.pc_en    = 1'b1;
        bus.busy     = 1'b1;
      end
      S_DONE:   bus.done = 1'b1;
      default:  ;
    endcase
  end

  assign bus.timeout   = timeout_q;
  assign bus.instr_cnt = instr_cnt;

  sat_counter #(.W(CW)) u_instr_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (run_clr),
    .en    (state_q == S_WB),
    .cnt   (instr_cnt)
  );

  sat_counter #(.W(CW)) u_cyc_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (run_clr),
    .en    (is_run_state(state_q)),
    .cnt   (cyc_cnt)
  );

endmodule

// File: tb/tb_run_sequencer.sv
// tb/tb_run_sequencer.sv - self-checking bench for run_sequencer
module tb_run_sequencer;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  run_sequencer_if #(.D(12), .CW(16)) bus0 ();
  run_sequencer_if #(.D(12), .CW(16)) bus1 ();

  run_sequencer #(.D(12), .CW(16), .MAX_CYC(4000)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0.slave));
  run_sequencer #(.D(12), .CW(16), .MAX_CYC(10)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1.slave));

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Program image for PCs 0..3; higher PCs decode as plain ALU, no RF write.
  logic [3:0]  prog_ld = '0, prog_st = '0, prog_rw = '0;
  logic [11:0] pc0, pc1, halt0 = '0, halt1 = '0;
  logic        req0 = 1'b0, req1 = 1'b0;

  function automatic logic bit_at(input logic [3:0] v, input logic [11:0] pc);
    return (pc < 12'd4) ? v[pc[1:0]] : 1'b0;
  endfunction

  // PC datapath model
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc0 <= '0;
      pc1 <= '0;
    end else begin
      if (bus0.pc_clr) pc0 <= '0; else if (bus0.pc_en) pc0 <= pc0 + 12'd1;
      if (bus1.pc_clr) pc1 <= '0; else if (bus1.pc_en) pc1 <= pc1 + 12'd1;
    end
  end

  assign bus0.req = req0;  assign bus0.halt_pc = halt0;  assign bus0.prog_ctr = pc0;
  assign bus0.is_load = bit_at(prog_ld, pc0);
  assign bus0.is_store = bit_at(prog_st, pc0);
  assign bus0.reg_write = bit_at(prog_rw, pc0);
  assign bus1.req = req1;  assign bus1.halt_pc = halt1;  assign bus1.prog_ctr = pc1;
  assign bus1.is_load = bit_at(prog_ld, pc1);
  assign bus1.is_store = bit_at(prog_st, pc1);
  assign bus1.reg_write = bit_at(prog_rw, pc1);

  // Scoreboard of per-instruction expectations for dut0
  typedef struct { int len; int mem; logic rf; } exp_t;
  exp_t sb_q[$];
  int mon_len = 0, mon_mem = 0;

  task automatic push_prog(input logic [11:0] halt);
    for (int i = 0; i <= int'(halt); i++) begin
      exp_t e;
      logic l, s;
      l = bit_at(prog_ld, 12'(i));
      s = bit_at(prog_st, 12'(i));
      e.len = (l || s) ? 5 : 4;
      e.mem = s ? 1 : 0;
      e.rf  = bit_at(prog_rw, 12'(i));
      sb_q.push_back(e);
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      check("strobe_excl",
            {31'd0, (bus0.mem_wr_en | bus0.rf_wr_en | bus0.pc_en) & (bus0.pc_clr | bus0.ir_ld)}, 0);
      if (bus0.ir_ld) begin
        mon_len = 1;
        mon_mem = 0;
      end else if (bus0.busy) begin
        mon_len++;
      end
      if (bus0.mem_wr_en) mon_mem++;
      if (bus0.pc_en) begin
        if (sb_q.size() == 0) begin
          check("sb_underflow", 1, 0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("instr_len", mon_len, e.len);
          check("instr_mem_wr", mon_mem, e.mem);
          check("instr_rf_wr", {31'd0, bus0.rf_wr_en}, {31'd0, e.rf});
        end
      end
    end
  end

  task automatic wait_done0(output int lat);
    lat = 0;
    forever begin
      @(posedge clk); #1;
      lat++;
      if (bus0.done) break;
      if (lat > 300) begin check("done0_wait", 0, 1); break; end
    end
  endtask

  task automatic run0(input logic [11:0] halt, output int lat);
    halt0 = halt;
    push_prog(halt);
    req0 = 1'b1;
    wait_done0(lat);
  endtask

  task automatic finish0();
    req0 = 1'b0;
    @(posedge clk); #1;
    check("idle_after_done", {30'd0, bus0.done, bus0.busy}, 0);
    check("sb_drained", sb_q.size(), 0);
  endtask

  task automatic wait_flag_en0(input int nth);
    int seen = 0;
    for (int c = 0; c < 200; c++) begin
      @(posedge clk); #1;
      if (bus0.flag_en) seen++;
      if (seen == nth) return;
    end
    check("flag_en_wait", seen, nth);
  endtask

  task automatic run1(input logic [11:0] halt, output int lat, output logic last_pc, output logic last_rf);
    logic p_pc = 1'b0, p_rf = 1'b0;
    halt1 = halt;
    req1 = 1'b1;
    lat = 0;
    forever begin
      @(posedge clk); #1;
      lat++;
      if (bus1.done) break;
      p_pc = bus1.pc_en;
      p_rf = bus1.rf_wr_en;
      if (lat > 300) begin check("done1_wait", 0, 1); break; end
    end
    last_pc = p_pc;
    last_rf = p_rf;
  endtask

  typedef struct { logic [3:0] ld, st, rw; logic [11:0] halt; int lat, cnt; } vec_t;
  vec_t vecs[6];

  initial begin
    int lat;
    logic lp, lr;

    vecs[0] = '{4'b0000, 4'b0000, 4'b1111, 12'd3, 18, 4};  // four ALU ops
    vecs[1] = '{4'b0000, 4'b0001, 4'b1110, 12'd3, 19, 4};  // store at PC0
    vecs[2] = '{4'b0010, 4'b0000, 4'b1111, 12'd3, 19, 4};  // load at PC1
    vecs[3] = '{4'b0100, 4'b0100, 4'b1011, 12'd2, 15, 3};  // load+store at PC2
    vecs[4] = '{4'b0000, 4'b0000, 4'b0000, 12'd0,  6, 1};  // halt at PC0
    vecs[5] = '{4'b0011, 4'b0000, 4'b0011, 12'd1, 12, 2};  // two loads

    @(posedge clk); #1;
    check("rst_outs0", {23'd0, bus0.pc_clr, bus0.ir_ld, bus0.flag_en, bus0.mem_wr_en,
          bus0.rf_wr_en, bus0.pc_en, bus0.busy, bus0.done, bus0.timeout}, 0);
    check("rst_cnt0", bus0.instr_cnt, 0);
    check("rst_outs1", {29'd0, bus1.busy, bus1.done, bus1.timeout}, 0);
    reset = 1'b1;
    @(posedge clk); #1;

    for (int v = 0; v < 6; v++) begin
      prog_ld = vecs[v].ld; prog_st = vecs[v].st; prog_rw = vecs[v].rw;
      run0(vecs[v].halt, lat);
      check($sformatf("v%0d_latency", v), lat, vecs[v].lat);
      check($sformatf("v%0d_done", v), {31'd0, bus0.done}, 1);
      check($sformatf("v%0d_busy", v), {31'd0, bus0.busy}, 0);
      check($sformatf("v%0d_timeout", v), {31'd0, bus0.timeout}, 0);
      check($sformatf("v%0d_instr_cnt", v), bus0.instr_cnt, vecs[v].cnt);
      finish0();
    end

    // DONE holds with req high, then a fresh request restarts cleanly
    prog_ld = 4'b0000; prog_st = 4'b0000; prog_rw = 4'b1111;
    run0(12'd3, lat);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      check("done_hold", {30'd0, bus0.done, bus0.pc_clr}, 2);
    end
    req0 = 1'b0;
    @(posedge clk); #1;
    check("done_release", {30'd0, bus0.done, bus0.busy}, 0);
    push_prog(12'd3);
    req0 = 1'b1;
    @(posedge clk); #1;
    check("restart_pc_clr", {31'd0, bus0.pc_clr}, 1);
    check("restart_cnt", bus0.instr_cnt, 0);
    wait_done0(lat);
    check("restart_latency", lat, 17);
    finish0();

    // Reset during MEM of the second instruction
    prog_ld = 4'b0010; prog_st = 4'b0000; prog_rw = 4'b1111;
    halt0 = 12'd3;
    push_prog(12'd3);
    req0 = 1'b1;
    wait_flag_en0(2);
    @(posedge clk); #1;
    check("mem_busy", {31'd0, bus0.busy}, 1);
    reset = 1'b0;
    #1;
    check("midrun_rst_outs", {23'd0, bus0.pc_clr, bus0.ir_ld, bus0.flag_en, bus0.mem_wr_en,
          bus0.rf_wr_en, bus0.pc_en, bus0.busy, bus0.done, bus0.timeout}, 0);
    check("midrun_rst_cnt", bus0.instr_cnt, 0);
    req0 = 1'b0;
    sb_q.delete();
    @(posedge clk); #1;
    reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      check("post_rst_idle", {29'd0, bus0.pc_clr, bus0.busy, bus0.done}, 0);
    end

    // req dropped during EXEC: run still completes at halt_pc
    prog_ld = 4'b0000; prog_st = 4'b0000; prog_rw = 4'b1111;
    halt0 = 12'd3;
    push_prog(12'd3);
    req0 = 1'b1;
    wait_flag_en0(1);
    req0 = 1'b0;
    wait_done0(lat);
    check("drop_req_done", {31'd0, bus0.done}, 1);
    check("drop_req_cnt", bus0.instr_cnt, 4);
    check("drop_req_timeout", {31'd0, bus0.timeout}, 0);
    finish0();

    // Watchdog (MAX_CYC=10): unreachable halt, expires in DECODE of 3rd op
    run1(12'hFFF, lat, lp, lr);
    check("wd_alu_latency", lat, 12);
    check("wd_alu_timeout", {31'd0, bus1.timeout}, 1);
    check("wd_alu_cnt", bus1.instr_cnt, 2);
    req1 = 1'b0;
    @(posedge clk); #1;
    check("wd_alu_release", {30'd0, bus1.done, bus1.busy}, 0);

    // Watchdog expiring in WB at the halt PC still wins and still retires
    prog_ld = 4'b0000; prog_st = 4'b0011; prog_rw = 4'b0011;
    run1(12'd1, lat, lp, lr);
    check("wd_wb_latency", lat, 12);
    check("wd_wb_timeout", {31'd0, bus1.timeout}, 1);
    check("wd_wb_cnt", bus1.instr_cnt, 2);
    check("wd_wb_strobes", {30'd0, lp, lr}, 3);
    req1 = 1'b0;
    @(posedge clk); #1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/run_sequencer.md
RUN_SEQUENCER -- requirements
Module: run_sequencer

Interface
REQ-001 Parameter D, default 12, program-counter width.
REQ-002 Parameter CW, default 16, width of the instruction and cycle counters.
REQ-003 Parameter MAX_CYC, default 16'd4000, watchdog limit in run cycles (must be ≥2).
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 req  input  1  run request from the testbench/host; four-phase handshake with done.
REQ-007 prog_ctr  input  D  current program counter from PC.
REQ-008 halt_pc  input  D  address whose completion ends the program.
REQ-009 is_load  input  1  decoded instruction reads data memory.
REQ-010 is_store  input  1  decoded instruction writes data memory.
REQ-011 reg_write  input  1  decoded instruction writes the register file.
REQ-012 pc_clr  output  1  one-cycle pulse that resets PC to 0.
REQ-013 ir_ld  output  1  latches mach_code into the instruction register.
REQ-014 flag_en  output  1  enables the zero/parity/carry flag registers.
REQ-015 mem_wr_en  output  1  data-memory write strobe.
REQ-016 rf_wr_en  output  1  register-file write strobe.
REQ-017 pc_en  output  1  advances PC (increment, or jump per PC's own enables).
REQ-018 busy  output  1  high in every state except IDLE and DONE.
REQ-019 done  output  1  program finished; held until req drops.
REQ-020 timeout  output  1  qualifies done: run ended by watchdog, not halt_pc.
REQ-021 instr_cnt  output  CW  instructions retired in the current run.

Function
REQ-022 States: IDLE, START, FETCH, DECODE, EXEC, MEM, WB, DONE; all outputs except instr_cnt and timeout are Moore decodes of the state register.
REQ-023 IDLE: all strobes low; req=1 -> START, else stay.
REQ-024 START: pc_clr=1; clears instr_cnt, the cycle counter and timeout; -> FETCH.
REQ-025 FETCH: ir_ld=1; -> DECODE.
REQ-026 DECODE: no strobes; -> EXEC.
REQ-027 EXEC: flag_en=1; (is_load|is_store) -> MEM, else -> WB.
REQ-028 MEM: mem_wr_en=is_store; -> WB. A load spends exactly one MEM cycle.
REQ-029 WB: rf_wr_en=reg_write; pc_en=1; instr_cnt increments; prog_ctr==halt_pc -> DONE, else -> FETCH.
REQ-030 DONE: done=1; req=0 -> IDLE, else stay. req=1 in DONE never starts a new run.
REQ-031 Latency: non-memory instruction takes 4 cycles (FETCH..WB); memory instruction takes 5.
REQ-032 The cycle counter increments in every state from FETCH through WB. When it equals MAX_CYC-1, the next state is DONE and timeout is set. This overrides every other transition, including the WB halt check.
REQ-033 If the watchdog fires in WB, rf_wr_en and pc_en still assert that cycle and instr_cnt still increments.
REQ-034 instr_cnt saturates at all-ones and never wraps; the cycle counter is the same width and saturates at all-ones.
REQ-035 req dropping while busy is ignored; the run continues to DONE.
REQ-036 is_store and is_load both high is treated as a store (mem_wr_en=1).
REQ-037 mem_wr_en, rf_wr_en and pc_en are never high in the same cycle as pc_clr or ir_ld.

Reset
REQ-038 reset low asynchronously forces IDLE, zeroes instr_cnt, the cycle counter and timeout; every output is 0 while in reset.
REQ-039 reset asserted mid-run abandons the run; after release the block waits in IDLE for a fresh req rising edge or level.

Structure
REQ-040 A shared package x9_pkg holds the state enum (seq_state_t), the constant D=12 and the counter width.
REQ-041 One sub-module, sat_counter (clear, enable, saturating, parameterised width), is instantiated twice: once for instr_cnt and once for the cycle counter.
REQ-042 Target size is 150-250 lines of RTL; no memories and no combinational loop through the inputs into the state register.

Verification
REQ-043 halt_pc=3; four ALU instructions at PCs 0-3; req held high -> done rises 18 cycles after START (1+4*4+1); instr_cnt=4; timeout=0.
REQ-044 Store at PC 0 (is_store=1) -> exactly one cycle with mem_wr_en=1, in MEM; rf_wr_en stays 0; that instruction takes 5 cycles.
REQ-045 MAX_CYC=10; halt_pc never reached -> DONE entered after cycle-counter value 9; timeout=1; done=1.
REQ-046 In DONE, hold req=1 for 5 cycles -> state stays DONE. Drop req -> IDLE next cycle. Raise req -> START with instr_cnt=0.
REQ-047 Pulse reset low during MEM of the 2nd instruction -> all outputs 0 immediately; after release, IDLE is held with req=0.
REQ-048 Drop req during EXEC -> run completes normally; done asserts at the halt_pc completion.
